ilas_generator: RTL
===================

Name: ilas_generator

Overview:
- Transmit-side link-establishment sequencer for a JESD204B TX lane, PARALLEL_OCTETS octets per cycle, pre-8b/10b.
- Emits Code Group Synchronisation (/K/ = K28.5) while SYNC~ is asserted, then a 4-multiframe Initial Lane Alignment Sequence carrying the link configuration, then passes user data through.
- Sits between the transport/framer and the 8b/10b encoder; produces the stream and K-flags that the lane receiver's ILAS detection consumes.

Parameters:
- PARALLEL_OCTETS, 4, octets per cycle; fixed at 4 in this revision.
- DATA_WIDTH, 32, PARALLEL_OCTETS*8.
- F, 2, octets per frame.
- K, 32, frames per multiframe; K*F must be divisible by 4 and at least 20.
- SYNC_REINIT_CYCLES, 4, consecutive low sync_ni cycles in ILAS/DATA that force re-entry to CGS.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous, active-low reset.
- sync_ni  in  1  SYNC~ from receiver, active low, already synchronised to clk_i.
- cfg_i  in  112  ILAS config octets 0..13; octet n = cfg_i[8n+7:8n], sent verbatim including FCHK.
- tx_data_i  in  DATA_WIDTH  user data; octet 0 = [7:0].
- tx_ready_o  out  1  tx_data_i is consumed this cycle.
- data_o  out  DATA_WIDTH  octet stream to encoder; octet 0 = [7:0] is first in time.
- char_is_k_o  out  PARALLEL_OCTETS  per-octet K-character flag.
- lmfc_o  out  1  one-cycle pulse on the first word of each local multiframe.
- ilas_active_o  out  1  high while ILAS words are on data_o.

Behaviour:
- MF_WORDS = K*F/4. LMFC word counter 0..MF_WORDS-1 is free-running from reset and wraps to 0. lmfc_o is registered and aligned with word 0 on data_o.
- All outputs are registered with 1-cycle latency (state/counter in cycle n -> data_o in cycle n+1).
- Reset values: data_o=32'hBCBCBCBC, char_is_k_o=4'hF, tx_ready_o=0, ilas_active_o=0, lmfc_o=0, word counter=0, state=ST_CGS. Reset mid-operation aborts any sequence; output is /K/ on the next cycle.
- ST_CGS:
  - Output all K28.5 (0xBC) with K=1111.
  - sync_ni is registered (sync_q). When sync_q=1 and the word counter = MF_WORDS-1, go to ST_ILAS with mf_idx=0. The first ILAS word therefore lands on an LMFC boundary.
- ST_ILAS (4 multiframes, mf_idx 0..3, octet index o = 4*word+lane):
  - Default octet value is the ramp o mod 256, with K=0.
  - Octet 0 of every multiframe is /R/ = 0x1C, K=1.
  - Last octet (o = K*F-1) of every multiframe is /A/ = 0x7C, K=1.
  - mf_idx=1 only: octet 1 is /Q/ = 0x9C, K=1; octets 2..15 are cfg octets 0..13, K=0.
  - ilas_active_o=1 for all 4*MF_WORDS words.
  - At word MF_WORDS-1 of mf_idx=3, go to ST_DATA.
- ST_DATA:
  - tx_ready_o=1; data_o <= tx_data_i; K=0000.
  - No character replacement and no scrambling.
- Re-init:
  - In ST_ILAS or ST_DATA, a counter tracks consecutive sync_q=0 cycles; any cycle with sync_q=1 clears it.
  - When the count reaches SYNC_REINIT_CYCLES, the next state is ST_CGS, and /K/ appears on the following output word.
  - Shorter low pulses (error reporting) are ignored.
  - The LMFC counter is never reset except by rst_ni.
- Simultaneous events:
  - Re-init has priority over the ILAS->DATA transition on the same cycle.
  - sync_q rising on a non-boundary word waits for the next boundary.
  - cfg_i is sampled live while mf_idx=1 words are generated; it must be held stable by the user.

Test Plan:
- Reset with sync_ni=0 for 100 cycles -> data_o=0xBCBCBCBC, K=1111 throughout; lmfc_o pulses every 16 cycles (defaults).
- Raise sync_ni 5 cycles after an lmfc_o pulse -> first ILAS word is coincident with the next lmfc_o. Word 0 = 0x0302011C, K=0001; word 15 = 0x7C3E3D3C, K=1000. ILAS lasts exactly 64 cycles, then tx_ready_o=1.
- cfg_i = octets 0x00..0x0D -> mf_idx=1 words 0..3 are 0x01009C1C (K=0011), 0x05040302, 0x09080706, 0x0D0C0B0A (K=0000).
- ST_DATA with tx_data_i=0xDEADBEEF -> data_o=0xDEADBEEF one cycle later, K=0000, ilas_active_o=0.
- sync_ni low for 3 cycles in DATA -> stays in DATA. Low for 4 cycles -> /K/ output follows; sync_ni re-raised -> full ILAS restarts on an LMFC boundary.
- Assert rst_ni=0 mid-ILAS (mf_idx=2) -> next cycle /K/, tx_ready_o=0, LMFC counter restarts at 0.

Source files
------------

// File: rtl/ilas_generator.sv
// ilas_generator
//   JESD204B transmit-lane link-establishment sequencer (4 octets/cycle, pre-8b/10b).
//   While SYNC~ is low: Code Group Synchronisation (all K28.5).
//   Once SYNC~ is high: on the next LMFC boundary, a 4-multiframe ILAS.
//   After the ILAS: user data passes through unchanged.
//   SYNC_REINIT_CYCLES consecutive low SYNC~ cycles during ILAS/DATA drop back to CGS.
//
// Ports
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   sync_ni        SYNC~ from receiver (already synchronised)
//   cfg_i          ILAS config octets 0..13; octet n = cfg_i[8n+7:8n]
//   tx_data_i      user data; octet 0 = [7:0]
//   tx_ready_o     tx_data_i is consumed this cycle
//   data_o         octet stream to encoder; octet 0 = [7:0] is first in time
//   char_is_k_o    per-octet K-character flag
//   lmfc_o         pulse on the first word of each local multiframe
//   ilas_active_o  high while ILAS words are on data_o
module ilas_generator #(
   parameter int PARALLEL_OCTETS    = 4,
   parameter int DATA_WIDTH         = PARALLEL_OCTETS*8,
   parameter int F                  = 2,
   parameter int K                  = 32,
   parameter int SYNC_REINIT_CYCLES = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       sync_ni,
   input  logic [111:0]               cfg_i,
   input  logic [DATA_WIDTH-1:0]      tx_data_i,
   output logic                       tx_ready_o,
   output logic [DATA_WIDTH-1:0]      data_o,
   output logic [PARALLEL_OCTETS-1:0] char_is_k_o,
   output logic                       lmfc_o,
   output logic                       ilas_active_o
);

   localparam int MF_OCTETS = K*F;
   localparam int MF_WORDS  = MF_OCTETS/4;
   localparam int CNT_W     = $clog2(MF_WORDS);
   localparam int LOW_W     = $clog2(SYNC_REINIT_CYCLES+1);
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(MF_WORDS-1);

   typedef enum logic [1:0] {ST_CGS, ST_ILAS, ST_DATA} state_t;

   state_t             state;
   logic [CNT_W-1:0]   word_cnt;   // free-running LMFC word counter
   logic [1:0]         mf_idx;
   logic [LOW_W-1:0]   low_cnt;    // consecutive sync_q=0 cycles in ILAS/DATA
   logic               sync_q;
   logic               reinit;

   logic [DATA_WIDTH-1:0]      ilas_word;
   logic [PARALLEL_OCTETS-1:0] ilas_k;

   // One ILAS octet at multiframe octet index o: {is_k, value}.
   // K*F >= 20 keeps /A/ clear of the /R/, /Q/ and config positions.
   function automatic logic [8:0] ilas_octet(input logic [15:0]  o,
                                             input logic [1:0]   mf,
                                             input logic [111:0] cfg);
      logic [3:0] sel;
      sel = 4'(o - 16'd2);
      if (o == 16'd0)                            return {1'b1, 8'h1C};
      else if (o == 16'(MF_OCTETS-1))            return {1'b1, 8'h7C};
      else if (mf == 2'd1 && o == 16'd1)         return {1'b1, 8'h9C};
      else if (mf == 2'd1 && o <= 16'd15)        return {1'b0, cfg[{sel, 3'b000} +: 8]};
      else                                       return {1'b0, o[7:0]};
   endfunction

   for (genvar l = 0; l < PARALLEL_OCTETS; l++) begin : g_lane
      logic [15:0] oct_idx;
      logic [8:0]  oct;
      assign oct_idx = 16'({word_cnt, 2'b00}) + 16'(l);
      assign oct     = ilas_octet(oct_idx, mf_idx, cfg_i);
      assign ilas_word[8*l +: 8] = oct[7:0];
      assign ilas_k[l]           = oct[8];
   end

   // Fourth (SYNC_REINIT_CYCLES-th) consecutive low sync_q while the link is up.
   assign reinit = (state != ST_CGS) && !sync_q &&
                   (low_cnt == LOW_W'(SYNC_REINIT_CYCLES-1));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state         <= ST_CGS;
         word_cnt      <= '0;
         mf_idx        <= '0;
         low_cnt       <= '0;
         sync_q        <= 1'b0;
         data_o        <= {PARALLEL_OCTETS{8'hBC}};
         char_is_k_o   <= '1;
         tx_ready_o    <= 1'b0;
         ilas_active_o <= 1'b0;
         lmfc_o        <= 1'b0;
      end else begin
         sync_q   <= sync_ni;
         lmfc_o   <= (word_cnt == '0);
         word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;

         unique case (state)
            ST_CGS: begin
               data_o        <= {PARALLEL_OCTETS{8'hBC}};
               char_is_k_o   <= '1;
               ilas_active_o <= 1'b0;
               tx_ready_o    <= 1'b0;
               low_cnt       <= '0;
               // Entering on the last word puts ILAS word 0 on an LMFC boundary.
               if (sync_q && word_cnt == LAST_WORD) begin
                  state  <= ST_ILAS;
                  mf_idx <= '0;
               end
            end
            ST_ILAS: begin
               data_o        <= ilas_word;
               char_is_k_o   <= ilas_k;
               ilas_active_o <= 1'b1;
               low_cnt       <= sync_q ? '0 : low_cnt + 1'b1;
               if (reinit) begin
                  state      <= ST_CGS;
                  low_cnt    <= '0;
                  tx_ready_o <= 1'b0;
               end else if (word_cnt == LAST_WORD) begin
                  mf_idx <= mf_idx + 1'b1;
                  if (mf_idx == 2'd3) begin
                     state      <= ST_DATA;
                     tx_ready_o <= 1'b1;
                  end
               end
            end
            ST_DATA: begin
               data_o        <= tx_data_i;
               char_is_k_o   <= '0;
               ilas_active_o <= 1'b0;
               low_cnt       <= sync_q ? '0 : low_cnt + 1'b1;
               if (reinit) begin
                  state      <= ST_CGS;
                  low_cnt    <= '0;
                  tx_ready_o <= 1'b0;
               end
            end
            default: begin
               state      <= ST_CGS;
               tx_ready_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
